// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: data-memory responder FSM states, default depth and LW/SW opcodes.
package mips32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_DEPTH_DEFAULT = 1024;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  // True when a word address falls outside a memory of the given depth.
  function automatic logic dmem_addr_oor(input logic [31:0] addr, input int unsigned depth);
    return (addr >= depth);
  endfunction

endpackage

// File: rtl/mips32_dmem_array.sv
// Single-port synchronous RAM, DEPTH x 32. Read data is registered at the access edge and
// forced to zero for stores and for accesses flagged by i_zero.
module mips32_dmem_array #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic              i_zero,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Storage has no reset so it maps onto a plain RAM macro.
  always_ff @(posedge clk1) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else if (i_en) begin
      r_rdata <= (i_we || i_zero) ? 32'd0 : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mips32_dmem_responder.sv
// Valid/ready data-memory responder for the MIPS32 MEM stage with WAIT_CYCLES access latency.
// Optional: define MIPS32_DMEM_RANGE_CHECK_EN to flag (and suppress) accesses at addr >= DEPTH.
module mips32_dmem_responder
  import mips32_pkg::*;
#(
  parameter int DEPTH       = DMEM_DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  dmem_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_rsp_valid;
  logic             r_rsp_err;

  logic        w_cnt_last;
  logic        w_access;
  logic        w_acc_we;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic        w_err;

  // With zero wait cycles the access happens on the acceptance edge, straight from the request.
  assign w_acc_we    = (WAIT_CYCLES == 0) ? req_we    : r_we;
  assign w_acc_addr  = (WAIT_CYCLES == 0) ? req_addr  : r_addr;
  assign w_acc_wdata = (WAIT_CYCLES == 0) ? req_wdata : r_wdata;

  assign w_cnt_last = (r_cnt <= CNT_W'(1));
  assign w_access   = !rst &&
                      (((r_state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                       ((r_state == WAIT) && w_cnt_last));

`ifdef MIPS32_DMEM_RANGE_CHECK_EN
  assign w_err = dmem_addr_oor(w_acc_addr, DEPTH);
`else
  assign w_err = 1'b0;
`endif

  assign req_ready = (r_state == IDLE) && !rst;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;

  mips32_dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk1    (clk1),
    .rst     (rst),
    .i_en    (w_access),
    .i_we    (w_acc_we && !w_err),
    .i_zero  (w_err),
    .i_addr  (w_acc_addr[ADDR_W-1:0]),
    .i_wdata (w_acc_wdata),
    .o_rdata (rsp_rdata)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          // Counter saturates at the access; it never wraps below zero.
          if (w_cnt_last) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_dmem_responder.sv
// Directed bench: instance 0 has WAIT_CYCLES=2, instance 1 has WAIT_CYCLES=0.
module tb_mips32_dmem_responder;

  logic        clk1;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_checks = 0;
  int n_fail   = 0;

  mips32_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk1(clk1), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mips32_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk1(clk1), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // One transaction on instance d; bp cycles of response back-pressure with req_valid held high.
  task automatic xact(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int bp, output logic [31:0] rdata, output logic err);
    int n;
    check($sformatf("ready_idle%0d", d), {31'd0, req_ready[d]}, 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    rsp_ready[d] = 1'b0;
    tick();
    req_valid[d] = (bp > 0);
    n = 1;
    while (!rsp_valid[d] && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("latency%0d", d), 32'(n), (d == 0) ? 32'd3 : 32'd1);
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    for (int i = 0; i < bp; i++) begin
      tick();
      check("bp_valid", {31'd0, rsp_valid[d]}, 32'd1);
      check("bp_rdata", rsp_rdata[d], rdata);
      check("bp_ready", {31'd0, req_ready[d]}, 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
    check($sformatf("rsp_drop%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
    check($sformatf("ready_back%0d", d), {31'd0, req_ready[d]}, 32'd1);
    check($sformatf("rdata_hold%0d", d), rsp_rdata[d], rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          acc;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ready", {31'd0, req_ready[0]}, 32'd0);
    check("rst_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("rst_rdata", rsp_rdata[0], 32'd0);
    check("rst_err",   {31'd0, rsp_err[0]}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, req_ready[0]}, 32'd1);

    // Store then load, WAIT_CYCLES=2
    xact(0, 1'b1, 32'd5, 32'hDEADBEEF, 0, rd, er);
    check("sw_rdata", rd, 32'd0);
    check("sw_err", {31'd0, er}, 32'd0);
    xact(0, 1'b0, 32'd5, 32'd0, 0, rd, er);
    check("lw_rdata", rd, 32'hDEADBEEF);
    xact(0, 1'b0, 32'd5, 32'd0, 5, rd, er);
    check("lw_bp_rdata", rd, 32'hDEADBEEF);

    // WAIT_CYCLES=0, top address
    xact(1, 1'b1, 32'd1023, 32'hCAFEF00D, 0, rd, er);
    check("w0_sw_rdata", rd, 32'd0);
    xact(1, 1'b0, 32'd1023, 32'd0, 0, rd, er);
    check("w0_lw_rdata", rd, 32'hCAFEF00D);

    // Back-to-back loads with rsp_ready held high: one acceptance every 2 cycles
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'd1023; rsp_ready[1] = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", {31'd0, rsp_valid[1]}, 32'(i % 2));
      if (rsp_valid[1]) check("b2b_rdata", rsp_rdata[1], 32'hCAFEF00D);
      if (req_valid[1] && req_ready[1]) acc++;
      tick();
    end
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd4);

    // Out-of-range store
    xact(0, 1'b1, 32'd0, 32'h00C0FFEE, 0, rd, er);
    xact(0, 1'b1, 32'd1024, 32'h12345678, 0, rd, er);
    check("oor_rdata", rd, 32'd0);
`ifdef MIPS32_DMEM_RANGE_CHECK_EN
    check("oor_err", {31'd0, er}, 32'd1);
    xact(0, 1'b0, 32'd0, 32'd0, 0, rd, er);
    check("oor_addr0", rd, 32'h00C0FFEE);
`else
    check("oor_err", {31'd0, er}, 32'd0);
    xact(0, 1'b0, 32'd0, 32'd0, 0, rd, er);
    check("oor_addr0", rd, 32'h12345678);
`endif

    // Reset while a store is in WAIT
    xact(0, 1'b1, 32'd7, 32'h11111111, 0, rd, er);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'd7; req_wdata[0] = 32'hA5A5A5A5;
    tick();
    req_valid[0] = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_ready", {31'd0, req_ready[0]}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_ready_after", {31'd0, req_ready[0]}, 32'd1);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid[0]) acc++;
      tick();
    end
    check("mid_rst_no_rsp", 32'(acc), 32'd0);
    xact(0, 1'b0, 32'd7, 32'd0, 0, rd, er);
    check("mid_rst_addr7", rd, 32'h11111111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
